frame_streamer: RTL and testbench

FRAME_STREAMER -- requirements
Module: frame_streamer

---
 rtl/frame_streamer_pkg.sv | 16 +
 rtl/frame_streamer.sv | 80 ++++++++
 tb/tb_frame_streamer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/frame_streamer_pkg.sv
// Shared constants and FSM encoding for the frame streamer.
package frame_streamer_pkg;

    localparam int FRAME_BYTES = 16;
    localparam int FRAME_WIDTH = 128;
    localparam int INDEX_W     = $clog2(FRAME_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT1,
        S_WAIT2,
        S_SHIFT
    } state_t;

endpackage

// File: rtl/frame_streamer.sv
// Fetches 128-bit frames from an upstream buffer RAM and streams them
// out as 16 bytes over a valid/ready byte interface.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int BUFFLENLOG2    = 9,
    parameter bit BYTE_ORDER_LSB = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Enable,
    input  logic [BUFFLENLOG2-1:0] FramesCnt,
    output logic                   FrameNext,
    input  logic [FRAME_WIDTH-1:0] Frame,
    output logic [7:0]             TxData,
    output logic                   TxValid,
    input  logic                   TxReady,
    output logic                   TxLast,
    output logic                   Busy,
    output logic [15:0]            FramesSent
);

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(FRAME_BYTES - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [FRAME_WIDTH-1:0]   r_frame;
    logic [INDEX_W-1:0]       r_index;
    logic [15:0]              r_sent;
    logic [INDEX_W-1:0]       w_sel;
    logic                     w_accept;
    logic                     w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Enable && (FramesCnt != '0)) w_state_next = S_REQ;
            S_REQ:   w_state_next = S_WAIT1;
            S_WAIT1: w_state_next = S_WAIT2;
            S_WAIT2: w_state_next = S_SHIFT;
            S_SHIFT: if (w_accept && w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_last   = (r_state == S_SHIFT) && (r_index == LAST_INDEX);
    assign w_accept = (r_state == S_SHIFT) && TxReady;

    // Upstream RAM read latency is two cycles after the FrameNext edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= '0;
            r_index <= '0;
            r_sent  <= '0;
        end else begin
            if (r_state == S_WAIT2) begin
                r_frame <= Frame;
                r_index <= '0;
            end else if (w_accept) begin
                if (w_last) r_sent  <= r_sent + 16'd1;
                else        r_index <= r_index + 1'b1;
            end
        end
    end

    assign w_sel = BYTE_ORDER_LSB ? r_index : (LAST_INDEX - r_index);

    assign FrameNext  = (r_state == S_REQ);
    assign TxValid    = (r_state == S_SHIFT);
    assign TxLast     = w_last;
    assign TxData     = (r_state == S_SHIFT) ? r_frame[{w_sel, 3'b000} +: 8] : '0;
    assign Busy       = (r_state != S_IDLE);
    assign FramesSent = r_sent;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench: two streamers (LSB-first and MSB-first) share stimulus;
// a monitor pops expected bytes whenever a byte is accepted.
module tb_frame_streamer;

    logic         clk;
    logic         rst;
    logic         en;
    logic [8:0]   cnt;
    logic [127:0] frame;
    logic         rdy;

    logic         fn_l, v_l, last_l, busy_l;
    logic [7:0]   d_l;
    logic [15:0]  sent_l;
    logic         fn_m, v_m, last_m, busy_m;
    logic [7:0]   d_m;
    logic [15:0]  sent_m;

    int unsigned  total;
    int unsigned  bad;
    int unsigned  fn_cnt;
    int unsigned  dec_timer;
    bit           auto_dec;
    bit           rand_ready;
    bit           prev_stalled;
    logic [8:0]   prev_out;
    logic [8:0]   q_lsb[$];
    logic [8:0]   q_msb[$];

    frame_streamer #(.BUFFLENLOG2(9), .BYTE_ORDER_LSB(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .Enable(en), .FramesCnt(cnt), .FrameNext(fn_l),
        .Frame(frame), .TxData(d_l), .TxValid(v_l), .TxReady(rdy), .TxLast(last_l),
        .Busy(busy_l), .FramesSent(sent_l)
    );

    frame_streamer #(.BUFFLENLOG2(9), .BYTE_ORDER_LSB(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .Enable(en), .FramesCnt(cnt), .FrameNext(fn_m),
        .Frame(frame), .TxData(d_m), .TxValid(v_m), .TxReady(rdy), .TxLast(last_m),
        .Busy(busy_m), .FramesSent(sent_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < 16; i++) begin
            q_lsb.push_back({i == 15, 8'(i)});
            q_msb.push_back({i == 15, 8'(15 - i)});
        end
    endtask

    task automatic drain(input int limit);
        int c;
        c = 0;
        while (c < limit && !(q_lsb.size() == 0 && q_msb.size() == 0 && !busy_l && !busy_m)) begin
            @(negedge clk);
            c++;
        end
        chk("drain_done", {31'd0, c < limit}, 32'd1);
    endtask

    task automatic wait_left(input int n, input int limit);
        int c;
        c = 0;
        while (c < limit && q_lsb.size() != n) begin
            @(negedge clk);
            c++;
        end
        chk("reach_byte", {31'd0, c < limit}, 32'd1);
    endtask

    task automatic idle_check(input string name, input int unsigned exp_fn, input logic [15:0] exp_sent);
        repeat (30) @(negedge clk);
        chk({name, "_fn"}, fn_cnt, exp_fn);
        chk({name, "_busy"}, {30'd0, busy_l, busy_m}, 32'd0);
        chk({name, "_sent_l"}, {16'd0, sent_l}, {16'd0, exp_sent});
        chk({name, "_sent_m"}, {16'd0, sent_m}, {16'd0, exp_sent});
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_lsb"}, {fn_l, v_l, last_l, busy_l, d_l, sent_l}, 32'd0);
        chk({name, "_msb"}, {fn_m, v_m, last_m, busy_m, d_m, sent_m}, 32'd0);
    endtask

    initial begin
        logic [8:0] exp;
        total = 0; bad = 0; fn_cnt = 0; dec_timer = 0;
        auto_dec = 1'b1; rand_ready = 1'b0; prev_stalled = 1'b0; prev_out = '0;
        rst = 1'b1; en = 1'b0; cnt = '0; rdy = 1'b1;
        for (int i = 0; i < 16; i++) frame[8*i +: 8] = 8'(i);

        fork
            forever begin
                @(negedge clk);
                if (rand_ready) rdy = 1'($urandom_range(0, 1));
                if (fn_l) begin
                    fn_cnt++;
                    if (auto_dec) dec_timer = 2;
                end else if (dec_timer > 0) begin
                    dec_timer--;
                    if (dec_timer == 0 && cnt != 0) cnt = cnt - 9'd1;
                end
                if (!rst) begin
                    if (prev_stalled) chk("stall_hold", {23'd0, v_l, last_l, d_l}, {23'd0, 1'b1, prev_out});
                    if (v_l && rdy) begin
                        if (q_lsb.size() == 0) chk("lsb_unexpected", {23'd0, last_l, d_l}, 32'h1ff);
                        else begin
                            exp = q_lsb.pop_front();
                            chk("lsb_byte", {23'd0, last_l, d_l}, {23'd0, exp});
                        end
                    end
                    if (v_m && rdy) begin
                        if (q_msb.size() == 0) chk("msb_unexpected", {23'd0, last_m, d_m}, 32'h1ff);
                        else begin
                            exp = q_msb.pop_front();
                            chk("msb_byte", {23'd0, last_m, d_m}, {23'd0, exp});
                        end
                    end
                    prev_stalled = v_l && !rdy;
                    prev_out     = {last_l, d_l};
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, sink always ready
        push_frame();
        cnt = 9'd1; en = 1'b1;
        drain(100);
        idle_check("single", 1, 16'd1);

        // Single frame, random back-pressure
        fn_cnt = 0;
        rand_ready = 1'b1;
        push_frame();
        cnt = 9'd1;
        drain(2000);
        rand_ready = 1'b0; rdy = 1'b1;
        idle_check("stall", 1, 16'd2);

        // Three frames with a lagging frame count
        fn_cnt = 0;
        push_frame(); push_frame(); push_frame();
        cnt = 9'd3;
        drain(300);
        idle_check("three", 3, 16'd5);

        // Enable dropped mid-frame; count stays non-zero
        fn_cnt = 0;
        push_frame();
        cnt = 9'd2;
        wait_left(11, 100);
        en = 1'b0;
        drain(100);
        idle_check("endrop", 1, 16'd6);
        chk("endrop_cnt_left", {23'd0, cnt}, 32'd1);

        // Reset mid-frame
        fn_cnt = 0;
        cnt = 9'd0;
        @(negedge clk);
        push_frame();
        cnt = 9'd1; en = 1'b1;
        wait_left(8, 100);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        q_lsb.delete(); q_msb.delete();
        prev_stalled = 1'b0; dec_timer = 0;
        cnt = 9'd0; fn_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        idle_check("post_rst", 0, 16'd0);
        chk("post_rst_valid", {30'd0, v_l, v_m}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
